// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer (MM:SS by default) with borrow-chain decrement,
// run/pause/done control and validated parallel load.
module bcd_countdown_timer #(
  parameter int PAIRS        = 2,
  parameter int TOP_TENS_MAX = 5
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 tick,
  input  logic                 load,
  input  logic [4*2*PAIRS-1:0] load_value,
  input  logic                 start,
  input  logic                 stop,
  output logic [4*2*PAIRS-1:0] count,
  output logic                 running,
  output logic                 paused,
  output logic                 zero,
  output logic                 done,
  output logic                 load_err
);

  localparam int NDIG = 2 * PAIRS;
  localparam int W    = 4 * NDIG;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [W-1:0]   count_r, count_s;
  logic           done_r, done_s;
  logic           load_err_r, load_err_s;
  logic [W-1:0]   dec_s;
  logic           zero_s;

  // Largest legal value of digit idx; the most significant digit has its own ceiling.
  function automatic logic [3:0] digit_max(input int idx);
    if (idx == NDIG - 1) begin
      return 4'(TOP_TENS_MAX);
    end else if ((idx % 2) == 1) begin
      return 4'd5;
    end else begin
      return 4'd9;
    end
  endfunction

  function automatic logic [3:0] wrap_value(input int idx);
    if ((idx % 2) == 1) begin
      return 4'd5;
    end else begin
      return 4'd9;
    end
  endfunction

  function automatic logic value_legal(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > digit_max(i)) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // A digit decrements only when every lower digit is zero; zero digits wrap.
  function automatic logic [W-1:0] decrement(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = wrap_value(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        end
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
      borrow = borrow & (v[4*i +: 4] == 4'd0);
    end
    return r;
  endfunction

  assign zero_s = (count_r == {W{1'b0}});
  assign dec_s  = decrement(count_r);

  // Next state, next count and one-cycle pulses; priority load > stop > start > tick.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    done_s     = 1'b0;
    load_err_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_PAUSED: begin
        if (load) begin
          if (value_legal(load_value)) begin
            count_s = load_value;
          end else begin
            load_err_s = 1'b1;
          end
        end else if (stop) begin
          if (state_r == ST_PAUSED) begin
            state_s = ST_IDLE;
          end else begin
            state_s = state_r;
          end
        end else if (start && !zero_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        // A load while running is ignored, so lower-priority inputs still act.
        if (stop) begin
          state_s = ST_PAUSED;
        end else if (tick && !zero_s) begin
          count_s = dec_s;
          if (dec_s == {W{1'b0}}) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
        count_s = {W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r    <= ST_IDLE;
      count_r    <= {W{1'b0}};
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      done_r     <= done_s;
      load_err_r <= load_err_s;
    end
  end

  assign count    = count_r;
  assign running  = (state_r == ST_RUN);
  assign paused   = (state_r == ST_PAUSED);
  assign zero     = zero_s;
  assign done     = done_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed scoreboard bench for bcd_countdown_timer: default MM:SS instance plus a
// TOP_TENS_MAX=9 instance sharing the control inputs but with its own load.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        clear, tick, load, start, stop, load9;
  logic [15:0] load_value, load_value9;
  logic [15:0] count, count9;
  logic        running, paused, zero, done, load_err;
  logic        running9, paused9, zero9, done9, load_err9;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [35:0] exp_q[$];
  string       tag_q[$];
  logic [15:0] exp_c9;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.PAIRS(2), .TOP_TENS_MAX(5)) dut (
    .clk(clk), .clear(clear), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .count(count), .running(running), .paused(paused),
    .zero(zero), .done(done), .load_err(load_err)
  );

  bcd_countdown_timer #(.PAIRS(2), .TOP_TENS_MAX(9)) dut9 (
    .clk(clk), .clear(clear), .tick(tick), .load(load9), .load_value(load_value9),
    .start(start), .stop(stop), .count(count9), .running(running9), .paused(paused9),
    .zero(zero9), .done(done9), .load_err(load_err9)
  );

  function automatic logic [15:0] to_bcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic chk(input string tag, input string what,
                     input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
  endtask

  // Push expectation, clock the inputs in, release pulses, then pop and compare.
  task automatic step(input string tag, input logic [15:0] ec, input logic er,
                      input logic ep, input logic ed, input logic ele);
    logic [35:0] e;
    string       t;
    exp_q.push_back({ec, er, ep, ed, ele, exp_c9});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    {clear, tick, load, start, stop, load9} = 6'b000000;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk(t, "count",    count,           e[35:20]);
    chk(t, "running",  16'(running),    16'(e[19]));
    chk(t, "paused",   16'(paused),     16'(e[18]));
    chk(t, "done",     16'(done),       16'(e[17]));
    chk(t, "load_err", 16'(load_err),   16'(e[16]));
    chk(t, "zero",     16'(zero),       16'(e[35:20] == 16'h0000));
    chk(t, "count9",   count9,          e[15:0]);
  endtask

  initial begin
    {clear, tick, load, start, stop, load9} = 6'b000000;
    load_value  = 16'h0000;
    load_value9 = 16'h0000;
    exp_c9      = 16'h0000;

    clear = 1'b1;
    step("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    load = 1'b1; load_value = 16'h0130;
    step("load_0130", 16'h0130, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("start_0130", 16'h0130, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 90; k++) begin
      tick = 1'b1;
      step("countdown", to_bcd(90 - k), (k != 90), 1'b0, (k == 90), 1'b0);
    end
    step("done_falls", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    load = 1'b1; load_value = 16'h0045;
    step("load_0045", 16'h0045, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("start_0045", 16'h0045, 1'b1, 1'b0, 1'b0, 1'b0);
    load = 1'b1; load_value = 16'h1000;
    step("load_in_run", 16'h0045, 1'b1, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    step("stop_pause", 16'h0045, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      step("tick_paused", 16'h0045, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    start = 1'b1;
    step("resume", 16'h0045, 1'b1, 1'b0, 1'b0, 1'b0);
    tick = 1'b1;
    step("tick_0044", 16'h0044, 1'b1, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    step("stop1", 16'h0044, 1'b0, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step("stop2_idle", 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0);

    load = 1'b1; load_value = 16'h0070;
    step("bad_0070", 16'h0044, 1'b0, 1'b0, 1'b0, 1'b1);
    step("err_falls", 16'h0044, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b1; load_value = 16'h0A00;
    step("bad_0A00", 16'h0044, 1'b0, 1'b0, 1'b0, 1'b1);
    load = 1'b1; load_value = 16'h6000;
    step("bad_6000", 16'h0044, 1'b0, 1'b0, 1'b0, 1'b1);

    load = 1'b1; load_value = 16'h0002;
    step("load_0002", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("start_0002", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1; stop = 1'b1;
    step("start_stop", 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0);
    load = 1'b1; load_value = 16'h0001; tick = 1'b1;
    step("load_vs_tick", 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    step("start_0001", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    clear = 1'b1; tick = 1'b1;
    step("clear_vs_tick", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("start_at_zero", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("no_done", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    load9 = 1'b1; load_value9 = 16'h9959; exp_c9 = 16'h9959;
    step("t9_load_9959", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("t9_start", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t9_start", "running9", 16'(running9), 16'h0001);
    tick = 1'b1; exp_c9 = 16'h9958;
    step("t9_tick", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    step("t9_stop1", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    stop = 1'b1;
    step("t9_stop2", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    load9 = 1'b1; load_value9 = 16'h6000; exp_c9 = 16'h6000;
    step("t9_load_6000", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t9_load_6000", "load_err9", 16'(load_err9), 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised multi-digit BCD countdown timer for the microwave controller. It generalises the single-digit mod-6 down-counter into a full MM:SS-style chain of digits with borrow propagation, a run/pause/done state machine and validated parallel load. The block sits between the keypad/load logic and the 7-segment display driver. It emits a one-cycle `done` pulse to the magnetron/beeper control when the count expires.

## Interface
- `PAIRS`, 2: number of base-60 digit pairs (ones mod 10, tens mod 6). 2 = MM:SS.
- `TOP_TENS_MAX`, 5: maximum value of the most significant digit. Legal range 5..9; 9 allows 99 minutes.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `clear`  in  1  synchronous, active-high reset; highest priority.
- `tick`  in  1  one-cycle count strobe (1 Hz enable from prescaler); ignored unless RUN.
- `load`  in  1  active-high parallel load request.
- `load_value`  in  4*2*PAIRS  BCD digits; digit 0 (seconds ones) in bits [3:0].
- `start`  in  1  level-sampled start request.
- `stop`  in  1  level-sampled pause request.
- `count`  out  4*2*PAIRS  current BCD value, registered.
- `running`  out  1  high in RUN.
- `paused`  out  1  high in PAUSED.
- `zero`  out  1  combinational, `count` == all zeros.
- `done`  out  1  one-cycle pulse on expiry.
- `load_err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, PAUSED.
- Reset (`clear`=1): state IDLE, `count`=0, `done`=0, `load_err`=0. Overrides every other input in that cycle.
- Priority per cycle: clear > load > stop > start > tick.
- Load is accepted only in IDLE or PAUSED, and only if every digit is legal: even digits ≤9, odd digits ≤5, top digit ≤`TOP_TENS_MAX`.
  - Accepted load: `count` := `load_value` and state is unchanged.
  - Illegal load: `count` is kept and `load_err` pulses.
  - Load in RUN: ignored with no `load_err`.
- start:
  - IDLE or PAUSED with `count`≠0 → RUN.
  - With `count`=0 → stay in the current state. No `done`.
- stop: RUN → PAUSED; PAUSED → IDLE (second press cancels, `count` kept). In IDLE it has no effect.
- Decrement on `tick` in RUN:
  - Digit i decrements when digits 0..i-1 are all zero. Otherwise it holds.
  - A digit at 0 that decrements wraps to 9 (even index) or 5 (odd index).
  - This applies to the top digit too, but the top digit never decrements at 0 because the count would be zero.
- Expiry: a tick in RUN with `count`==1 (only digit 0 = 1, rest 0) sets `count`=0, state → IDLE, and `done`=1 for exactly one cycle.
- `count` never underflows below 0 and never holds an illegal digit.
- start and stop high together: stop wins.
- tick coincident with an accepted load in PAUSED: the load wins and the tick is discarded.

## Timing
- All outputs are registered except `zero`. Latency is 1 cycle from a sampled input to its effect on `count` or state.
- `done` rises on the same edge that writes `count`=0 and falls on the next edge unless `clear` is asserted. `running` falls on that same edge.
- `load_err` is high for exactly the cycle after the rejected load.
- tick must be a single-cycle strobe. Back-to-back ticks decrement once per cycle.
- `clear` mid-RUN: the next edge gives IDLE and `count`=0, with no `done` pulse.
- Width arithmetic: digit compare and borrow use 4-bit unsigned values. The borrow chain is combinational across all 2*PAIRS digits in a single cycle.

## Test plan
- Reset, then load 0x0130 (01:30), start, 90 ticks → `count` steps 0130→0129…0100→0059…0001→0000. `done` pulses once on the 90th tick, then `running`=0.
- Load 0x1000 in RUN → ignored. Load 0x0070 in IDLE → `load_err` 1 cycle, `count` unchanged. Load 0x0A00 → rejected.
- RUN at 0x0045, stop → PAUSED. 3 ticks → count stays 0x0045. start → RUN, tick → 0x0044. stop twice → IDLE.
- Start with `count`=0 → remains IDLE, `running`=0, `done`=0. start+stop in the same cycle during RUN → PAUSED.
- `TOP_TENS_MAX`=9, load 0x9959, 1 tick → 0x9958. Loading 0x6000 is accepted only with `TOP_TENS_MAX`≥6.
- `clear` asserted at 0x0001 coincident with tick → `count`=0, no `done`, state IDLE.
